// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared constants and state type for rr_arbiter
package rr_arbiter_pkg;

  localparam int DEFAULT_INPUT = 8;
  localparam int DEFAULT_WIDTH = 32;

  // Output slot occupancy: EMPTY has no beat held, FULL holds one beat.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin search from ptr+1 with wrap
module rr_priority_pick import rr_arbiter_pkg::*; #(
  parameter int INPUT     = DEFAULT_INPUT,
  parameter int SEL_WIDTH = $clog2(INPUT)
) (
  input  logic [INPUT-1:0]     req,
  input  logic [SEL_WIDTH-1:0] ptr,
  input  logic                 valid,
  output logic [INPUT-1:0]     grant,
  output logic [SEL_WIDTH-1:0] idx
);

  // Scan ptr+1, ptr+2, ... wrapping at INPUT; the last candidate is ptr itself,
  // so a lone requester that was just served still wins.
  always_comb begin
    int                   pos;
    logic [SEL_WIDTH-1:0] pos_s;
    logic                 found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    pos_s = '0;
    for (int k = 1; k <= INPUT; k++) begin
      pos   = (int'(ptr) + k) % INPUT;
      pos_s = SEL_WIDTH'(pos);
      if (valid && !found && req[pos_s]) begin
        found        = 1'b1;
        grant[pos_s] = 1'b1;
        idx          = pos_s;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin N:1 arbiter with one-beat output register; optional grant hold under RR_ARBITER_LOCK_EN
module rr_arbiter import rr_arbiter_pkg::*; #(
  parameter int INPUT     = DEFAULT_INPUT,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEL_WIDTH = $clog2(INPUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INPUT-1:0]     req,
  input  logic [WIDTH-1:0]     in [0:INPUT-1],
  output logic [INPUT-1:0]     in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic [SEL_WIDTH-1:0] out_sel
`ifdef RR_ARBITER_LOCK_EN
  ,
  input  logic [INPUT-1:0]     lock
`endif
);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]     out_q, out_d;

  logic                 slot_free;
  logic                 pick_valid;
  logic [INPUT-1:0]     grant_rr;
  logic [SEL_WIDTH-1:0] idx_rr;
  logic [INPUT-1:0]     grant;
  logic [SEL_WIDTH-1:0] idx;
  logic                 xfer_in;
  logic                 xfer_out;

  assign out_valid  = (state_q == FULL);
  assign xfer_out   = out_valid & out_ready;
  // Slot can take a new beat if empty or being drained this cycle; reset blocks all grants.
  assign slot_free  = (state_q == EMPTY) | out_ready;
  assign pick_valid = slot_free & rst_n;

  rr_priority_pick #(
    .INPUT     (INPUT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .grant (grant_rr),
    .idx   (idx_rr)
  );

`ifdef RR_ARBITER_LOCK_EN
  logic                 lock_q, lock_d;
  logic [SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic                 hold_active;

  // The hold survives only while its owner keeps requesting.
  assign hold_active = lock_q & req[lock_idx_q];

  // Held owner bypasses the rotation; otherwise use the round-robin pick.
  always_comb begin
    grant = grant_rr;
    idx   = idx_rr;
    if (hold_active) begin
      grant             = '0;
      grant[lock_idx_q] = pick_valid;
      idx               = lock_idx_q;
    end
  end

  // Each accepted beat re-arms or releases the hold from its owner's lock bit.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (lock_q && !req[lock_idx_q]) begin
      lock_d = 1'b0;
    end
    if (xfer_in) begin
      lock_d     = lock[idx];
      lock_idx_d = idx;
    end
  end

  // Hold registers; reset drops any hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  // Without hold support every free cycle is arbitrated by rotation.
  always_comb begin
    grant = grant_rr;
    idx   = idx_rr;
  end
`endif

  assign in_ready = grant;
  assign xfer_in  = |(req & grant);

  // Next-state: load on accept (wins over drain), empty on drain alone, else hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    out_d   = out_q;
    if (xfer_in) begin
      state_d = FULL;
      ptr_d   = idx;
      sel_d   = idx;
      out_d   = in[idx];
    end else if (xfer_out) begin
      state_d = EMPTY;
    end
  end

  // State, pointer and output registers; ptr resets to the last index so 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= SEL_WIDTH'(INPUT - 1);
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  assign out     = out_q;
  assign out_sel = sel_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed vector bench for rr_arbiter; lock sequence under RR_ARBITER_LOCK_EN
module tb_rr_arbiter;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] exp_ir;
    logic       exp_v;
    logic [2:0] exp_sel;
    logic       exp_zero;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [31:0] in_d [0:7];
  logic [7:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [2:0]  out_sel;
`ifdef RR_ARBITER_LOCK_EN
  logic [7:0]  lock_i;
`endif

  int n_checks = 0;
  int n_err    = 0;
  vec_t vecs[$];

  rr_arbiter #(.INPUT(8), .WIDTH(32), .SEL_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (in_d),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_sel   (out_sel)
`ifdef RR_ARBITER_LOCK_EN
    ,
    .lock      (lock_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] in_val(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic rd, input logic [7:0] ir,
                     input logic v, input logic [2:0] s, input logic z);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = rd; t.exp_ir = ir;
    t.exp_v = v; t.exp_sel = s; t.exp_zero = z;
    vecs.push_back(t);
  endtask

  // Drive at posedge+1, check in_ready at negedge, check registers at next posedge+1.
  task automatic apply(input int n, input vec_t t);
    logic [31:0] exp_out;
    rst_n     = t.rst_n;
    req       = t.req;
    out_ready = t.rdy;
    @(negedge clk);
    check($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(t.exp_ir));
    @(posedge clk);
    #1;
    exp_out = t.exp_zero ? 32'h0 : in_val(int'(t.exp_sel));
    check($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(t.exp_v));
    check($sformatf("v%0d out_sel", n), 32'(out_sel), 32'(t.exp_sel));
    check($sformatf("v%0d out", n), out, exp_out);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) in_d[i] = in_val(i);
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
    lock_i = '0;
`endif
    @(posedge clk); #1;

    // reset: no grant even with requests
    add(0, 8'hFF, 1, 8'h00, 0, 0, 1);
    // full rotation 0..7 then wrap to 0, one beat per cycle
    for (int k = 0; k < 8; k++) add(1, 8'hFF, 1, 8'h01 << k, 1, 3'(k), 0);
    add(1, 8'hFF, 1, 8'h01, 1, 0, 0);
    // drain with no requests: valid clears, data holds; idle holds too
    add(1, 8'h00, 1, 8'h00, 0, 0, 0);
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    // reset so ptr returns to 7, then alternate between 0 and 7
    add(0, 8'h00, 1, 8'h00, 0, 0, 1);
    add(1, 8'h81, 1, 8'h01, 1, 0, 0);
    add(1, 8'h81, 1, 8'h80, 1, 7, 0);
    add(1, 8'h81, 1, 8'h01, 1, 0, 0);
    add(1, 8'h81, 1, 8'h80, 1, 7, 0);
    // beat from 3, stalled 5 cycles, then drain and new grant in the same cycle
    add(1, 8'h08, 1, 8'h08, 1, 3, 0);
    for (int k = 0; k < 5; k++) add(1, 8'hFF, 0, 8'h00, 1, 3, 0);
    add(1, 8'hFF, 1, 8'h10, 1, 4, 0);
    // lone requester 5 served every cycle
    for (int k = 0; k < 4; k++) add(1, 8'h20, 1, 8'h20, 1, 5, 0);
    // requester 6 drops before grant; 1 wins instead
    add(1, 8'h40, 0, 8'h00, 1, 5, 0);
    add(1, 8'h02, 1, 8'h02, 1, 1, 0);
    add(1, 8'h00, 1, 8'h00, 0, 1, 0);
    // empty slot accepts even with out_ready low, then stalls
    add(1, 8'h04, 0, 8'h04, 1, 2, 0);
    add(1, 8'h04, 0, 8'h00, 1, 2, 0);
    // reset while holding a beat discards it; requester 0 first afterwards
    add(0, 8'hFF, 0, 8'h00, 0, 0, 1);
    add(1, 8'hFF, 1, 8'h01, 1, 0, 0);

    for (int n = 0; n < vecs.size(); n++) apply(n, vecs[n]);

`ifdef RR_ARBITER_LOCK_EN
    begin
      vec_t t;
      logic [2:0] lsel [0:4];
      logic [7:0] llock [0:4];
      lsel[0] = 2; lsel[1] = 2; lsel[2] = 2; lsel[3] = 2; lsel[4] = 3;
      llock[0] = 8'h04; llock[1] = 8'h04; llock[2] = 8'h04; llock[3] = 8'h00; llock[4] = 8'h00;
      t.rst_n = 0; t.req = 8'h00; t.rdy = 1; t.exp_ir = 8'h00; t.exp_v = 0; t.exp_sel = 0; t.exp_zero = 1;
      apply(100, t);
      // serve requester 1 so rotation would next pick 2
      t.rst_n = 1; t.req = 8'h02; t.exp_ir = 8'h02; t.exp_v = 1; t.exp_sel = 1; t.exp_zero = 0;
      apply(101, t);
      for (int k = 0; k < 5; k++) begin
        lock_i = llock[k];
        t.req = 8'hFF; t.exp_ir = 8'h01 << lsel[k]; t.exp_sel = lsel[k];
        apply(110 + k, t);
      end
      lock_i = '0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter INPUT, default 8, number of requesters.
REQ-002 Parameter WIDTH, default 32, data width per requester.
REQ-003 Parameter SEL_WIDTH, default $clog2(INPUT), width of the encoded select.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 req  input  INPUT  per-requester valid.
REQ-007 in  input  WIDTH x INPUT (unpacked [0:INPUT-1])  per-requester data.
REQ-008 in_ready  output  INPUT  one-hot acceptance; at most one bit high per cycle.
REQ-009 out_valid  output  1  registered output holds a beat.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out  output  WIDTH  registered data of the accepted beat.
REQ-012 out_sel  output  SEL_WIDTH  encoded index of the requester that supplied out.
REQ-013 lock  input  INPUT  per-requester hold request; present only with RR_ARBITER_LOCK_EN.

Function
REQ-014 Transfer in: occurs when req[i] & in_ready[i]; transfer out: occurs when out_valid & out_ready.
REQ-015 Slot is free when out_valid=0 or a transfer out occurs this cycle.
REQ-016 in_ready is combinational: when slot free, the requester granted by round-robin gets in_ready; otherwise in_ready is all zero.
REQ-017 Round-robin: search starts at ptr+1 mod INPUT and wraps from INPUT-1 to 0; the first index with req high wins.
REQ-018 On a transfer in, out<=in[i], out_sel<=i, out_valid<=1 and ptr<=i at the next edge; latency is 1 cycle.
REQ-019 A transfer out with no transfer in clears out_valid; out and out_sel hold their last values.
REQ-020 A transfer out and a transfer in in the same cycle are both honoured, giving full throughput of one beat per cycle.
REQ-021 out, out_sel and out_valid are stable while out_valid=1 and out_ready=0.
REQ-022 No req high: no grant and ptr unchanged.
REQ-023 A single active requester is granted on every free cycle.
REQ-024 req may drop before it is granted with no side effect.
REQ-025 States: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-026 EMPTY to FULL on a transfer in.
REQ-027 FULL stays FULL on stall, or on a transfer out together with a transfer in.
REQ-028 FULL to EMPTY on a transfer out with no transfer in.

Reset
REQ-029 While rst_n=0 at a rising edge: out_valid=0, out=0, out_sel=0 and ptr=INPUT-1, so requester 0 has first priority.
REQ-030 in_ready is all zero during any cycle where rst_n=0.
REQ-031 Reset mid-operation discards any held beat and any lock without emitting it.

Configuration
REQ-032 With RR_ARBITER_LOCK_EN defined, the lock port exists.
REQ-033 With RR_ARBITER_LOCK_EN, after a transfer in from i with lock[i]=1, requester i holds the grant, bypassing the rotation, until a transfer in from i with lock[i]=0 or until req[i] drops.
REQ-034 Without RR_ARBITER_LOCK_EN, the lock port and hold logic are absent and every free cycle is arbitrated per REQ-017.

Structure
REQ-035 Shared package rr_arbiter_pkg holds the default INPUT/WIDTH constants and the state enum (EMPTY, FULL).
REQ-036 The round-robin search is one sub-module, rr_priority_pick: combinational, taking req, ptr and valid, and producing a one-hot grant plus an encoded index.
REQ-037 rr_arbiter contains the state, the ptr and output registers, and the lock logic.

Verification
REQ-038 Reset, then req=8'hFF with out_ready=1 held -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles; out=in[out_sel].
REQ-039 req=8'b1000_0001, ptr=7 after reset -> grants alternate 0,7,0,7; no other in_ready bits are set.
REQ-040 Beat from requester 3 is held with out_ready=0 for 5 cycles -> out, out_sel=3 and out_valid are stable, and in_ready=0 throughout; in the first cycle out_ready=1, a new grant issues in that same cycle.
REQ-041 Only req[5] high, out_ready=1 -> in_ready[5]=1 every cycle; out_sel=5 on every beat.
REQ-042 rst_n=0 asserted while out_valid=1 -> out_valid=0 and out=0 at the next edge; the next grant goes to requester 0.
REQ-043 With RR_ARBITER_LOCK_EN: req=8'hFF and lock[2]=1 for 3 beats, then 0 -> out_sel=2,2,2,2 then 3.
